jtag_tap_param: RTL and testbench
=================================

Name: jtag_tap_param

Overview:
- Parametrised IEEE 1149.1-style TAP controller, the next generation of the fixed 4-bit-IR TAP in main_module.
- Generalised in IR width, IDCODE value and number of external data-register chains (boundary scan, BIST config/status, user).
- Owns the 16-state TAP FSM, IR, BYPASS and IDCODE registers.
- Selects one external DR chain by opcode match and muxes its serial output onto TDO.

Parameters:
- IR_WIDTH, 4: instruction register width, minimum 2.
- NUM_EXT, 4: number of external DR chains, minimum 1.
- EXT_OPCODES, {4'h9,4'h5,4'h8,4'h4}: packed NUM_EXT*IR_WIDTH opcodes; slot k selects chain k.
- IDCODE_VALUE, 32'h1234_5679: device ID; bit 0 must be 1.

Ports:
- TCK in 1: test clock, the only clock.
- TRST in 1: asynchronous, active-low reset.
- TMS in 1: mode select, sampled on posedge TCK.
- TDI in 1: serial data in.
- TDO out 1: serial data out, changes on negedge TCK.
- TDO_OE out 1: high in Shift-IR/Shift-DR only.
- TAP_STATE out 4: current FSM state.
- IR_OUT out IR_WIDTH: active instruction.
- EXT_SEL out NUM_EXT: one-hot chain select, all zero if no match.
- EXT_TDO in NUM_EXT: serial output of each external chain.
- CAPTURE_DR out 1: high while state is Capture-DR.
- SHIFT_DR out 1: high while state is Shift-DR.
- UPDATE_DR out 1: high while state is Update-DR.

Behaviour:
- State encoding:
  - TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5.
  - SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
- FSM:
  - Standard 1149.1 transitions on posedge TCK.
  - TMS=1 for 5 consecutive TCK reaches TLR from any state.
- TRST low (async, any state including mid-shift):
  - TAP_STATE=F, shift registers cleared, TDO=0, TDO_OE=0.
  - IR_OUT=IDCODE opcode (2), so EXT_SEL=0.
  - Entering TLR synchronously has the same effect on IR_OUT.
- IR path:
  - CapIR: IR shift register loads {0..0,0,1} (bit0=1, bit1=0).
  - ShIR: shift right, TDI into MSB.
  - UpdIR: IR_OUT latches the shift register on negedge TCK.
  - IR_OUT is stable at all other times.
- Decode from IR_OUT:
  - All-ones: BYPASS.
  - 2: IDCODE.
  - Match against EXT_OPCODES: EXT_SEL bit k; lowest k wins on duplicate entries.
  - Anything else (e.g. 4'h6): BYPASS.
- BYPASS register: 1 bit, captures 0, shifts TDI, so one cycle of TCK latency TDI to TDO.
- IDCODE register: 32 bits, captures IDCODE_VALUE, shifts right with TDI into MSB.
- External chains:
  - Capture, shift and update happen outside this block on posedge TCK, gated by EXT_SEL & the strobe.
  - TDO in ShDR = EXT_TDO[k].
- TDO: registered on negedge TCK.
  - ShIR: IR shift bit0.
  - ShDR: selected DR bit0.
  - Otherwise 0, with TDO_OE low.
- Simultaneous events: TRST low overrides TMS in the same cycle.
- IR_OUT never changes during a DR scan.

Optional Feature:
- Macro: JTAG_TAP_IDCODE_EN.
- Defined: IDCODE register present; reset/TLR instruction is 2.
- Undefined:
  - No IDCODE register; opcode 2 decodes as BYPASS.
  - Reset/TLR instruction is all-ones (BYPASS).
  - A DR scan after reset returns a single 0 then TDI.

Decomposition:
- Package jtag_pkg: 16 state localparams, BYPASS/IDCODE opcodes, IR capture pattern, and the legacy opcodes SAMPLE_PRELOAD 1, EXTEST 4, INTEST 8, BIST 3, BIST_CONF 5, BIST_STATUS 7, BIST_USER_TEST 9.
- Sub-module jtag_tap_fsm: state register plus next-state logic, exporting TAP_STATE.
- Register and mux logic stay in jtag_tap_param.

Test Plan:
- Reset: TRST=0 at any time → TAP_STATE=F, IR_OUT=4'h2, TDO_OE=0, EXT_SEL=0.
- IDCODE: after reset, RTI then 32-bit DR scan with TDI=0 → TDO yields 32'h1234_5679 LSB first.
  - First bit 1, then TDO=0 after the 32 bits.
- IR load 4'h4 (EXTEST, slot 0):
  - CapIR/ShIR → TDO reads 1,0,0,0.
  - After UpdIR: IR_OUT=4'h4, EXT_SEL=4'b0001.
  - 13-bit DR scan (13'h000F) → SHIFT_DR high 13 cycles, TDO tracks EXT_TDO[0].
  - Through PauseDR/Ex2DR, UPDATE_DR is high for exactly one cycle.
- Bypass:
  - IR 4'hF then DR shift 8'hA5 → TDO = 0 followed by A5 bits delayed one TCK.
  - Repeat with IR 4'h6 → identical result.
- TMS reset: from ShDR hold TMS=1 → TAP_STATE F after exactly 5 posedges; IR_OUT=4'h2.
- Mid-shift TRST: assert TRST during ShIR after 2 bits of 4'h8 → immediate F.
  - IR_OUT stays 4'h2; a full reload of 4'h8 then gives EXT_SEL=4'b0010.
- With JTAG_TAP_IDCODE_EN undefined: reset → IR_OUT=4'hF; IR 4'h2 behaves as bypass.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, fixed opcodes, IR capture pattern
// and the legacy instruction set of the original 4-bit TAP.
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_EX2DR   = 4'h0,
        TAP_EX1DR   = 4'h1,
        TAP_SHDR    = 4'h2,
        TAP_PAUSEDR = 4'h3,
        TAP_SELIR   = 4'h4,
        TAP_UPDDR   = 4'h5,
        TAP_CAPDR   = 4'h6,
        TAP_SELDR   = 4'h7,
        TAP_EX2IR   = 4'h8,
        TAP_EX1IR   = 4'h9,
        TAP_SHIR    = 4'hA,
        TAP_PAUSEIR = 4'hB,
        TAP_RTI     = 4'hC,
        TAP_UPDIR   = 4'hD,
        TAP_CAPIR   = 4'hE,
        TAP_TLR     = 4'hF
    } tap_state_e;

    // Truncated to the IR width at the point of use; all-ones at any width.
    localparam logic [31:0] OPC_BYPASS_ALL = 32'hFFFF_FFFF;
    localparam int unsigned OPC_IDCODE     = 2;

    localparam int unsigned OPC_SAMPLE_PRELOAD = 1;
    localparam int unsigned OPC_EXTEST         = 4;
    localparam int unsigned OPC_INTEST         = 8;
    localparam int unsigned OPC_BIST           = 3;
    localparam int unsigned OPC_BIST_CONF      = 5;
    localparam int unsigned OPC_BIST_STATUS    = 7;
    localparam int unsigned OPC_BIST_USER_TEST = 9;

    // Low two bits loaded into the IR shift register in Capture-IR.
    localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

    function automatic logic tap_is_shift(input tap_state_e s);
        return (s == TAP_SHIR) || (s == TAP_SHDR);
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller; state advances on posedge TCK and
// an active-low asynchronous reset forces Test-Logic-Reset.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst_n,
    input  logic       tms,
    output logic [3:0] tap_state
);

    tap_state_e state_q, state_d;

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state_q <= TAP_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TAP_TLR:     state_d = tms ? TAP_TLR     : TAP_RTI;
            TAP_RTI:     state_d = tms ? TAP_SELDR   : TAP_RTI;
            TAP_SELDR:   state_d = tms ? TAP_SELIR   : TAP_CAPDR;
            TAP_CAPDR:   state_d = tms ? TAP_EX1DR   : TAP_SHDR;
            TAP_SHDR:    state_d = tms ? TAP_EX1DR   : TAP_SHDR;
            TAP_EX1DR:   state_d = tms ? TAP_UPDDR   : TAP_PAUSEDR;
            TAP_PAUSEDR: state_d = tms ? TAP_EX2DR   : TAP_PAUSEDR;
            TAP_EX2DR:   state_d = tms ? TAP_UPDDR   : TAP_SHDR;
            TAP_UPDDR:   state_d = tms ? TAP_SELDR   : TAP_RTI;
            TAP_SELIR:   state_d = tms ? TAP_TLR     : TAP_CAPIR;
            TAP_CAPIR:   state_d = tms ? TAP_EX1IR   : TAP_SHIR;
            TAP_SHIR:    state_d = tms ? TAP_EX1IR   : TAP_SHIR;
            TAP_EX1IR:   state_d = tms ? TAP_UPDIR   : TAP_PAUSEIR;
            TAP_PAUSEIR: state_d = tms ? TAP_EX2IR   : TAP_PAUSEIR;
            TAP_EX2IR:   state_d = tms ? TAP_UPDIR   : TAP_SHIR;
            TAP_UPDIR:   state_d = tms ? TAP_SELDR   : TAP_RTI;
            default:     state_d = TAP_TLR;
        endcase
    end

    assign tap_state = state_q;

endmodule

// File: rtl/jtag_tap_param.sv
// Parametrised TAP: IR, BYPASS, optional IDCODE register and TDO mux over
// external DR chains. Macro JTAG_TAP_IDCODE_EN enables the IDCODE register.
module jtag_tap_param
    import jtag_pkg::*;
#(
    parameter int                          IR_WIDTH     = 4,
    parameter int                          NUM_EXT      = 4,
    parameter logic [NUM_EXT*IR_WIDTH-1:0] EXT_OPCODES  = {4'h9, 4'h5, 4'h8, 4'h4},
    parameter logic [31:0]                 IDCODE_VALUE = 32'h1234_5679
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_OE,
    output logic [3:0]          TAP_STATE,
    output logic [IR_WIDTH-1:0] IR_OUT,
    output logic [NUM_EXT-1:0]  EXT_SEL,
    input  logic [NUM_EXT-1:0]  EXT_TDO,
    output logic                CAPTURE_DR,
    output logic                SHIFT_DR,
    output logic                UPDATE_DR
);

    localparam logic [IR_WIDTH-1:0] BYPASS_OPC = IR_WIDTH'(OPC_BYPASS_ALL);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(IR_CAPTURE_LSBS);
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IDCODE_OPC = IR_WIDTH'(OPC_IDCODE);
    localparam logic [IR_WIDTH-1:0] RESET_OPC  = IDCODE_OPC;
`else
    localparam logic [IR_WIDTH-1:0] RESET_OPC  = BYPASS_OPC;
`endif

    logic [3:0]          tap_state_w;
    tap_state_e          state;
    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
    logic [IR_WIDTH-1:0] ir_out_q, ir_out_d;
    logic                bypass_q, bypass_d;
    logic                tdo_q, tdo_d;
    logic                tdo_oe_q, tdo_oe_d;
    logic [NUM_EXT-1:0]  ext_match;
    logic [NUM_EXT-1:0]  ext_sel;
    logic                sel_idcode;
    logic                sel_ext;
    logic                sel_bypass;
    logic                dr_tdo;

    jtag_tap_fsm u_fsm (
        .tck       (TCK),
        .trst_n    (TRST),
        .tms       (TMS),
        .tap_state (tap_state_w)
    );

    assign state = tap_state_e'(tap_state_w);

    // Instruction decode; scanning downwards lets the lowest slot win on duplicates.
    always_comb begin
        ext_match = '0;
        for (int k = NUM_EXT - 1; k >= 0; k--) begin
            if (ir_out_q == EXT_OPCODES[k*IR_WIDTH +: IR_WIDTH]) begin
                ext_match = NUM_EXT'(1) << k;
            end
        end
        sel_idcode = 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
        sel_idcode = (ir_out_q == IDCODE_OPC);
`endif
        ext_sel    = ((ir_out_q == BYPASS_OPC) || sel_idcode) ? '0 : ext_match;
        sel_ext    = |ext_sel;
        sel_bypass = !sel_idcode && !sel_ext;
    end

`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0] idcode_q, idcode_d;

    always_comb begin
        idcode_d = idcode_q;
        if (sel_idcode && state == TAP_CAPDR) begin
            idcode_d = IDCODE_VALUE;
        end else if (sel_idcode && state == TAP_SHDR) begin
            idcode_d = {TDI, idcode_q[31:1]};
        end
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            idcode_q <= '0;
        end else begin
            idcode_q <= idcode_d;
        end
    end
`else
    logic unused_idcode;
    assign unused_idcode = ^IDCODE_VALUE;
`endif

    always_comb begin
        dr_tdo = bypass_q;
        if (sel_ext) begin
            dr_tdo = |(ext_sel & EXT_TDO);
        end
`ifdef JTAG_TAP_IDCODE_EN
        if (sel_idcode) begin
            dr_tdo = idcode_q[0];
        end
`endif
    end

    // Shift registers capture and shift on the rising edge.
    always_comb begin
        ir_sr_d  = ir_sr_q;
        bypass_d = bypass_q;
        case (state)
            TAP_CAPIR: ir_sr_d = IR_CAPTURE;
            TAP_SHIR:  ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
            TAP_CAPDR: if (sel_bypass) bypass_d = 1'b0;
            TAP_SHDR:  if (sel_bypass) bypass_d = TDI;
            default:   ;
        endcase
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_sr_q  <= '0;
            bypass_q <= 1'b0;
        end else begin
            ir_sr_q  <= ir_sr_d;
            bypass_q <= bypass_d;
        end
    end

    // Instruction update and TDO drive happen on the falling edge.
    always_comb begin
        ir_out_d = ir_out_q;
        if (state == TAP_UPDIR) begin
            ir_out_d = ir_sr_q;
        end else if (state == TAP_TLR) begin
            ir_out_d = RESET_OPC;
        end
        tdo_oe_d = tap_is_shift(state);
        tdo_d    = 1'b0;
        if (state == TAP_SHIR) begin
            tdo_d = ir_sr_q[0];
        end else if (state == TAP_SHDR) begin
            tdo_d = dr_tdo;
        end
    end

    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_out_q <= RESET_OPC;
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            ir_out_q <= ir_out_d;
            tdo_q    <= tdo_d;
            tdo_oe_q <= tdo_oe_d;
        end
    end

    assign TDO        = tdo_q;
    assign TDO_OE     = tdo_oe_q;
    assign TAP_STATE  = tap_state_w;
    assign IR_OUT     = ir_out_q;
    assign EXT_SEL    = ext_sel;
    assign CAPTURE_DR = (state == TAP_CAPDR);
    assign SHIFT_DR   = (state == TAP_SHDR);
    assign UPDATE_DR  = (state == TAP_UPDDR);

endmodule

// File: tb/tb_jtag_tap_param.sv
// Scoreboard bench for jtag_tap_param: drivers push expected TDO bits, a
// monitor pops one whenever TDO_OE is high. Honours JTAG_TAP_IDCODE_EN.
module tb_jtag_tap_param;

    localparam logic [31:0] IDV = 32'h1234_5679;
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [3:0] RST_IR = 4'h2;
`else
    localparam logic [3:0] RST_IR = 4'hF;
`endif

    logic       TCK = 1'b0;
    logic       TRST = 1'b0;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       TDO;
    logic       TDO_OE;
    logic [3:0] TAP_STATE;
    logic [3:0] IR_OUT;
    logic [3:0] EXT_SEL;
    logic [3:0] EXT_TDO = 4'h0;
    logic       CAPTURE_DR;
    logic       SHIFT_DR;
    logic       UPDATE_DR;

    logic [0:0] exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         bit_idx = 0;
    int         cnt_cap = 0;
    int         cnt_sh = 0;
    int         cnt_upd = 0;

    jtag_tap_param dut (
        .TCK        (TCK),
        .TRST       (TRST),
        .TMS        (TMS),
        .TDI        (TDI),
        .TDO        (TDO),
        .TDO_OE     (TDO_OE),
        .TAP_STATE  (TAP_STATE),
        .IR_OUT     (IR_OUT),
        .EXT_SEL    (EXT_SEL),
        .EXT_TDO    (EXT_TDO),
        .CAPTURE_DR (CAPTURE_DR),
        .SHIFT_DR   (SHIFT_DR),
        .UPDATE_DR  (UPDATE_DR)
    );

    // Clock and watchdog
    always #10 TCK = ~TCK;

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: TDO_OE acts as the valid qualifier for a TDO bit.
    initial begin
        logic [0:0] e;
        forever begin
            @(negedge TCK);
            #5;
            if (TDO_OE === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL tdo_unexpected: got %b, required no output", TDO);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("tdo_bit%0d", bit_idx), {31'd0, TDO}, {31'd0, e});
                    bit_idx++;
                end
            end
        end
    end

    // Drivers: each step is one posedge; returns 5 after the following negedge.
    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(negedge TCK);
        #5;
        if (CAPTURE_DR) cnt_cap++;
        if (SHIFT_DR) cnt_sh++;
        if (UPDATE_DR) cnt_upd++;
    endtask

    function automatic logic [3:0] ext_word(input logic b, input int sel);
        logic [3:0] m;
        m = (sel < 0) ? 4'b0000 : (4'b0001 << sel);
        return b ? m : ~m;
    endfunction

    task automatic shift_ir(input logic [3:0] v);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(i == 3, v[i]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // DR scan from RTI, leaving via Pause-DR / Exit2-DR; caller pushes TDO bits.
    task automatic dr_scan(input logic [63:0] tdi, input logic [63:0] ext_pat, input int n,
                           input int sel, input string tag);
        cnt_cap = 0;
        cnt_sh  = 0;
        cnt_upd = 0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        EXT_TDO = ext_word(ext_pat[0], sel);
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i + 1 < n) EXT_TDO = ext_word(ext_pat[i+1], sel);
            step(i == n - 1, tdi[i]);
        end
        EXT_TDO = 4'h0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check({tag, "_capture_cycles"}, cnt_cap, 1);
        check({tag, "_shift_cycles"}, cnt_sh, n);
        check({tag, "_update_cycles"}, cnt_upd, 1);
        check({tag, "_back_in_rti"}, {28'd0, TAP_STATE}, 32'hC);
    endtask

    // Expected TDO for a 33-bit scan under the reset instruction (or IR 2).
    task automatic push_scan33(input logic [32:0] tdi);
        for (int i = 0; i < 33; i++) begin
`ifdef JTAG_TAP_IDCODE_EN
            if (i < 32) exp_q.push_back(IDV[i]);
            else exp_q.push_back(tdi[0]);
`else
            if (i == 0) exp_q.push_back(1'b0);
            else exp_q.push_back(tdi[i-1]);
`endif
        end
    endtask

    task automatic push_bypass_a5();
        logic [7:0] d;
        d = 8'hA5;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    endtask

    initial begin
        logic [12:0] ext_pat;
        ext_pat = 13'h1A6B;

        // Reset state
        repeat (2) @(negedge TCK);
        #5;
        check("rst_state", {28'd0, TAP_STATE}, 32'hF);
        check("rst_ir_out", {28'd0, IR_OUT}, {28'd0, RST_IR});
        check("rst_tdo_oe", {31'd0, TDO_OE}, 0);
        check("rst_tdo", {31'd0, TDO}, 0);
        check("rst_ext_sel", {28'd0, EXT_SEL}, 0);
        TRST = 1'b1;
        step(1'b0, 1'b0);
        check("rti_state", {28'd0, TAP_STATE}, 32'hC);

        // DR scan under the reset instruction
        push_scan33(33'h1_0000_0003);
        dr_scan(64'h1_0000_0003, 64'd0, 33, -1, "reset_dr");
        check("reset_dr_ir_stable", {28'd0, IR_OUT}, {28'd0, RST_IR});

        // EXTEST on chain 0
        shift_ir(4'h4);
        check("extest_ir_out", {28'd0, IR_OUT}, 32'h4);
        check("extest_ext_sel", {28'd0, EXT_SEL}, 32'h1);
        for (int i = 0; i < 13; i++) exp_q.push_back(ext_pat[i]);
        dr_scan(64'h000F, {51'd0, ext_pat}, 13, 0, "extest_dr");
        check("extest_ir_stable", {28'd0, IR_OUT}, 32'h4);

        // Bypass via all-ones and via an unused opcode
        shift_ir(4'hF);
        check("bypf_ext_sel", {28'd0, EXT_SEL}, 0);
        push_bypass_a5();
        dr_scan(64'h0A5, 64'd0, 9, -1, "bypf_dr");
        shift_ir(4'h6);
        check("byp6_ext_sel", {28'd0, EXT_SEL}, 0);
        push_bypass_a5();
        dr_scan(64'h0A5, 64'd0, 9, -1, "byp6_dr");

        // Opcode 2: IDCODE when enabled, bypass otherwise
        shift_ir(4'h2);
        check("op2_ext_sel", {28'd0, EXT_SEL}, 0);
        push_scan33(33'h1_0000_0003);
        dr_scan(64'h1_0000_0003, 64'd0, 33, -1, "op2_dr");

        // TMS-held reset from Shift-DR on chain 2
        shift_ir(4'h5);
        check("conf_ext_sel", {28'd0, EXT_SEL}, 32'h4);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        EXT_TDO = 4'b0100;
        exp_q.push_back(1'b1);
        step(1'b0, 1'b0);
        check("tms_rst_in_shdr", {28'd0, TAP_STATE}, 32'h2);
        EXT_TDO = 4'h0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        check("tms_rst_after4", {28'd0, TAP_STATE}, 32'h4);
        step(1'b1, 1'b0);
        check("tms_rst_after5", {28'd0, TAP_STATE}, 32'hF);
        check("tms_rst_ir_out", {28'd0, IR_OUT}, {28'd0, RST_IR});
        check("tms_rst_ext_sel", {28'd0, EXT_SEL}, 0);
        step(1'b0, 1'b0);

        // TRST in the middle of an IR shift of 4'h8
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        #2;
        TRST = 1'b0;
        #1;
        check("trst_mid_state", {28'd0, TAP_STATE}, 32'hF);
        check("trst_mid_tdo_oe", {31'd0, TDO_OE}, 0);
        check("trst_mid_tdo", {31'd0, TDO}, 0);
        check("trst_mid_ir_out", {28'd0, IR_OUT}, {28'd0, RST_IR});
        check("trst_mid_ext_sel", {28'd0, EXT_SEL}, 0);
        @(negedge TCK);
        #5;
        TRST = 1'b1;
        step(1'b0, 1'b0);
        shift_ir(4'h8);
        check("intest_ir_out", {28'd0, IR_OUT}, 32'h8);
        check("intest_ext_sel", {28'd0, EXT_SEL}, 32'h2);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        dr_scan(64'h0, 64'h9, 4, 1, "intest_dr");

        step(1'b0, 1'b0);
        check("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
